// File: rtl/vga_apb_master.sv
// APB requester: turns single-beat valid/ready commands into APB setup/access
// transfers and returns read data, slave error and timeout as a one-cycle response.
module vga_apb_master #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Saturation value; with timeout disabled the 1-bit counter just sticks at 1.
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
    localparam int unsigned CNT_HIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    assign cmd_ready = (state == IDLE);

    // The wait cycle that would bring the counter to TIMEOUT_CYCLES aborts the transfer.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_W'(CNT_HIT));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite   <= cmd_write;
                        paddr    <= cmd_addr;
                        if (cmd_write) begin
                            pwdata <= cmd_wdata;
                        end
                        psel     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= IDLE;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                    end else begin
                        if (wait_cnt != CNT_W'(CNT_MAX)) begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                        if (timeout_hit) begin
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            state       <= IDLE;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_rdata   <= '0;
                        end
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_apb_master.sv
// Directed bench for vga_apb_master: vector table of single transfers plus
// hand-written back-to-back and mid-transfer reset sequences.
module tb_vga_apb_master;

    logic        pclk;
    logic        preset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks;
    int errors;
    logic [31:0] model_wdata;

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        slverr;
        int          waits;
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    vec_t vecs [8];

    vga_apb_master #(
        .ADDR_WIDTH    (12),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Issue one command and follow it through SETUP/ACCESS to the response.
    task automatic run_txn(input vec_t v, input int idx);
        int   acc;
        logic done;
        logic addr_ok;
        acc     = 0;
        done    = 1'b0;
        addr_ok = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        chk($sformatf("v%0d cmd_ready_idle", idx), 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        cmd_wdata = 32'h1BAD_F00D;
        if (v.write) model_wdata = v.wdata;
        chk($sformatf("v%0d setup_psel_penable", idx), 32'({psel, penable, cmd_ready}), 32'b100);
        chk($sformatf("v%0d setup_paddr", idx), 32'(paddr), 32'(v.addr));
        chk($sformatf("v%0d setup_pwrite", idx), 32'(pwrite), 32'(v.write));
        chk($sformatf("v%0d setup_pwdata", idx), pwdata, model_wdata);
        step();
        for (int c = 0; c < 40 && !done; c++) begin
            if (!(psel && penable)) break;
            acc++;
            if (paddr !== v.addr || pwdata !== model_wdata) addr_ok = 1'b0;
            if (acc > v.waits) begin
                pready  = 1'b1;
                prdata  = v.rd;
                pslverr = v.slverr;
            end else begin
                pready  = 1'b0;
                prdata  = 32'hDEAD_BEEF;
                pslverr = 1'b1;
            end
            step();
            if (rsp_valid) done = 1'b1;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        chk($sformatf("v%0d rsp_valid_seen", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d access_cycles", idx), 32'(acc), 32'(v.exp_acc));
        chk($sformatf("v%0d addr_data_stable", idx), 32'(addr_ok), 32'd1);
        chk($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
        chk($sformatf("v%0d rsp_timeout", idx), 32'(rsp_timeout), 32'(v.exp_to));
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d rsp_bus_idle", idx), 32'({psel, penable, cmd_ready}), 32'b001);
        step();
        chk($sformatf("v%0d rsp_pulse_one_cycle", idx), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d rsp_hold", idx), {rsp_rdata[29:0], rsp_err, rsp_timeout},
            {v.exp_rdata[29:0], v.exp_err, v.exp_to});
    endtask

    initial begin
        logic seen;
        checks      = 0;
        errors      = 0;
        model_wdata = 32'h0;
        preset_n    = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = 12'h0;
        cmd_wdata   = 32'h0;
        prdata      = 32'h0;
        pready      = 1'b0;
        pslverr     = 1'b0;

        //          wr    addr     wdata         prdata        serr  waits acc exp_rdata     err   to
        vecs[0] = '{1'b1, 12'h004, 32'h000A0050, 32'h77777777, 1'b0, 0,   1,  32'h00000000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 12'h008, 32'h0,        32'h0000000B, 1'b0, 0,   1,  32'h0000000B, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 12'h00C, 32'h0,        32'h12345678, 1'b0, 3,   4,  32'h12345678, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 12'h010, 32'h55AA55AA, 32'h0,        1'b1, 0,   1,  32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 12'h014, 32'h0,        32'hCAFEF00D, 1'b1, 0,   1,  32'h00000000, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 12'h018, 32'h0,        32'h0,        1'b0, 100, 16, 32'h00000000, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 12'hFFC, 32'hFFFFFFFF, 32'h0,        1'b0, 0,   1,  32'h00000000, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 12'h000, 32'h0,        32'hA5A5A5A5, 1'b0, 15,  16, 32'hA5A5A5A5, 1'b0, 1'b0};

        #12;
        chk("reset_ctrl", 32'({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}), 32'd0);
        chk("reset_paddr", 32'(paddr), 32'd0);
        chk("reset_pwdata", pwdata, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        preset_n = 1'b1;
        step();
        step();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], i);
        end

        // Held command during a busy transfer is taken in the rsp_valid cycle.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h040;
        step();
        cmd_addr  = 12'h044;
        cmd_write = 1'b1;
        cmd_wdata = 32'h0BADCAFE;
        chk("b2b_ready_setup", 32'(cmd_ready), 32'd0);
        step();
        chk("b2b_ready_access", 32'(cmd_ready), 32'd0);
        pready = 1'b1;
        prdata = 32'h13572468;
        step();
        pready = 1'b0;
        chk("b2b_rsp_a", {rsp_rdata[30:0], rsp_valid}, {31'h13572468, 1'b1});
        chk("b2b_ready_rsp", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid   = 1'b0;
        model_wdata = 32'h0BADCAFE;
        chk("b2b_setup_b", 32'({psel, penable, pwrite, paddr}), 32'({3'b101, 12'h044}));
        chk("b2b_pwdata_b", pwdata, 32'h0BADCAFE);
        step();
        pready = 1'b1;
        step();
        pready = 1'b0;
        chk("b2b_rsp_b", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'b100);
        chk("b2b_rdata_b", rsp_rdata, 32'd0);
        step();

        // Asynchronous reset in the middle of ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h020;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        chk("rst_pre_access", 32'({psel, penable}), 32'b11);
        #2;
        preset_n = 1'b0;
        #1;
        chk("rst_async_bus", 32'({psel, penable, rsp_valid}), 32'd0);
        chk("rst_async_ready", 32'(cmd_ready), 32'd1);
        step();
        preset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            seen = seen | rsp_valid | psel;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
        chk("rst_ready_after", 32'(cmd_ready), 32'd1);
        model_wdata = 32'h0;
        run_txn(vecs[1], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
